// File: rtl/mem_seq_ctrl.sv
// Memory-instruction sequencer feeding Data_Fetch: accepts one LOAD/STORE at a time,
// steps through every PE-group pass for the matrix size and reports DONE, or ERR on timeout.
module mem_seq_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  input  logic [1:0]        INSTR_OP,
  input  logic [1:0]        INSTR_DIMEN,
  input  logic [ADDR_W-1:0] INSTR_ADDR,
  input  logic              FETCH_DONE,
  input  logic              STORE_DONE,
  output logic [1:0]        DIMEN,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic              ADDR_START,
  output logic              WRADDR_START,
  output logic              ADDR_RST,
  output logic [1:0]        PE_SEL,
  output logic              PE_SEL_2x2,
  output logic              PE_SEL_4,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RUN,
    S_ST_RUN,
    S_CLR,
    S_FIN,
    S_ERR
  } state_e;

  state_e              state, state_nxt;
  logic [3:0]          pass, pass_nxt;
  logic [3:0]          last_pass;
  logic [TW-1:0]       timer, timer_nxt;
  logic                abort, abort_nxt;
  logic                op_st, op_st_nxt;
  logic                latch_op;
  logic                accept;
  logic                is_mem_op;
  logic [1:0]          dimen_q;
  logic [ADDR_W-1:0]   addr_q;

  logic ready_q, busy_q, addr_start_q, wraddr_start_q, addr_rst_q, done_q, err_q;

  assign accept    = INSTR_VALID && ready_q;
  assign is_mem_op = (INSTR_OP == 2'b01) || (INSTR_OP == 2'b10);

  always_comb begin
    case (dimen_q)
      2'b00:   last_pass = 4'd0;
      2'b01:   last_pass = 4'd3;
      default: last_pass = 4'd15;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missed default here would synthesize a latch.
  always_comb begin
    state_nxt = state;
    pass_nxt  = pass;
    timer_nxt = timer;
    abort_nxt = abort;
    op_st_nxt = op_st;
    latch_op  = 1'b0;

    case (state)
      S_IDLE: begin
        if (accept && is_mem_op) begin
          latch_op  = 1'b1;
          pass_nxt  = 4'd0;
          timer_nxt = '0;
          abort_nxt = 1'b0;
          op_st_nxt = INSTR_OP[1];
          if (INSTR_DIMEN == 2'b11)
            state_nxt = S_ERR;
          else
            state_nxt = INSTR_OP[1] ? S_ST_RUN : S_LD_RUN;
        end
      end
      S_LD_RUN, S_ST_RUN: begin
        // A done arriving on the timeout cycle still counts as success.
        if ((state == S_LD_RUN) ? FETCH_DONE : STORE_DONE) begin
          state_nxt = S_CLR;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt = S_CLR;
          abort_nxt = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_CLR: begin
        if (abort) begin
          state_nxt = S_ERR;
        end else if (pass == last_pass) begin
          state_nxt = S_FIN;
        end else begin
          pass_nxt  = pass + 4'd1;
          timer_nxt = '0;
          state_nxt = op_st ? S_ST_RUN : S_LD_RUN;
        end
      end
      S_FIN, S_ERR: begin
        state_nxt = S_IDLE;
        pass_nxt  = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        pass_nxt  = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state          <= S_IDLE;
      pass           <= 4'd0;
      timer          <= '0;
      abort          <= 1'b0;
      op_st          <= 1'b0;
      dimen_q        <= 2'b00;
      addr_q         <= '0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      addr_start_q   <= 1'b0;
      wraddr_start_q <= 1'b0;
      addr_rst_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state <= state_nxt;
      pass  <= pass_nxt;
      timer <= timer_nxt;
      abort <= abort_nxt;
      op_st <= op_st_nxt;
      if (latch_op) begin
        dimen_q <= INSTR_DIMEN;
        addr_q  <= INSTR_ADDR;
      end
      // Outputs decode the next state so they line up with the state register.
      ready_q        <= (state_nxt == S_IDLE);
      busy_q         <= (state_nxt != S_IDLE);
      addr_start_q   <= (state_nxt == S_LD_RUN);
      wraddr_start_q <= (state_nxt == S_ST_RUN);
      addr_rst_q     <= (state_nxt == S_CLR);
      done_q         <= (state_nxt == S_FIN);
      err_q          <= (state_nxt == S_ERR);
    end
  end

  assign INSTR_READY  = ready_q;
  assign BUSY         = busy_q;
  assign ADDR_START   = addr_start_q;
  assign WRADDR_START = wraddr_start_q;
  assign ADDR_RST     = addr_rst_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign DIMEN        = dimen_q;
  assign ADDRESS      = addr_q;
  assign PE_SEL       = pass[1:0];
  assign PE_SEL_2x2   = pass[2];
  assign PE_SEL_4     = pass[3];

endmodule
